enemy_scan_ctrl: RTL and testbench

Multi-enemy combat controller for the boxhead game. Time-multiplexes one external hit-test unit across `ENEMY_NUM` enemy slots with a valid/ready request and a response strobe, and owns per-slot hit points, per-slot respawn timers and the score. Sits between the player attack logic and the enemy position/rendering blocks, replacing per-enemy hit/blood logic with a single sequenced datapath.

---
 rtl/enemy_scan_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_enemy_scan_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_scan_ctrl.sv
// Multi-enemy combat controller: sequences one shared hit-test unit across enemy slots and owns HP, respawn timers and score.
// Optional macro RESPAWN_STAGGER_EN: at most one slot (lowest index) respawns per divided tick.
module enemy_scan_ctrl #(
    parameter int unsigned ENEMY_NUM    = 8,
    parameter int unsigned RESPAWN_TIME = 200,
    parameter int unsigned FRAME_DIV    = 4,
    parameter int unsigned MAX_HP       = 100,
    parameter int unsigned DAMAGE       = 100
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       Attack_On,
    output logic       Chk_Valid,
    output logic [2:0] Chk_Slot,
    input  logic       Chk_Ready,
    input  logic       Rsp_Valid,
    input  logic       Rsp_Hit,
    output logic [7:0] Enemy_Alive,
    output logic [7:0] Score,
    output logic       Scan_Busy,
    output logic       Scan_Overrun
);

    localparam int unsigned SLOT_W       = 3;
    localparam int unsigned HP_W         = 7;
    localparam int unsigned TMR_W        = 8;
    localparam int unsigned DIV_W        = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned ALIVE_ALL_I  = (1 << ENEMY_NUM) - 1;
    localparam logic [7:0]       ALIVE_ALL = 8'(ALIVE_ALL_I);
    localparam logic [HP_W-1:0]  HP_MAX    = HP_W'(MAX_HP);
    localparam logic [HP_W-1:0]  DMG       = HP_W'(DAMAGE);
    localparam logic [TMR_W-1:0] TMR_END   = TMR_W'(RESPAWN_TIME);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(FRAME_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t            r_state;
    logic              r_frm_d1;
    logic              r_frm_d2;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [SLOT_W-1:0] r_slot;
    logic              r_chk_valid;
    logic              r_busy;
    logic              r_overrun;
    logic [7:0]        r_score;
    logic [7:0]        r_alive;
    logic [HP_W-1:0]   r_hp    [ENEMY_NUM];
    logic [TMR_W-1:0]  r_timer [ENEMY_NUM];

    logic                 w_tick;
    logic                 w_div_tick;
    logic                 w_last;
    logic                 w_rsp_hit;
    logic                 w_score_inc;
    logic [7:0]           w_alive_nxt;
    logic [ENEMY_NUM-1:0] w_expired;
    logic [ENEMY_NUM-1:0] w_grant;
    logic [HP_W-1:0]      w_hp_nxt  [ENEMY_NUM];
    logic [TMR_W-1:0]     w_tmr_nxt [ENEMY_NUM];

    assign w_tick     = r_frm_d1 & ~r_frm_d2;
    assign w_div_tick = w_tick && (r_div_cnt == DIV_LAST);
    assign w_last     = (r_slot == SLOT_W'(ENEMY_NUM - 1));
    assign w_rsp_hit  = (r_state == S_WAIT) && Rsp_Valid && Rsp_Hit;

    always_comb begin : expire_detect
        w_expired = '0;
        for (int i = 0; i < int'(ENEMY_NUM); i++) begin
            w_expired[i] = w_div_tick && (r_hp[i] == '0) && (r_timer[i] == TMR_END);
        end
    end

    // Staggered mode: scanning downward leaves only the lowest expired slot granted.
    always_comb begin : respawn_grant
        w_grant = '0;
`ifdef RESPAWN_STAGGER_EN
        for (int i = int'(ENEMY_NUM) - 1; i >= 0; i--) begin
            if (w_expired[i]) begin
                w_grant    = '0;
                w_grant[i] = 1'b1;
            end
        end
`else
        w_grant = w_expired;
`endif
    end

    // Respawn is applied first so a same-cycle hit lands on the refreshed HP.
    always_comb begin : slot_next
        logic [HP_W-1:0] hp_base;
        w_score_inc = 1'b0;
        w_alive_nxt = '0;
        hp_base     = '0;
        for (int i = 0; i < int'(ENEMY_NUM); i++) begin
            hp_base     = w_grant[i] ? HP_MAX : r_hp[i];
            w_hp_nxt[i] = hp_base;
            if ((r_hp[i] != '0) || w_grant[i]) begin
                w_tmr_nxt[i] = '0;
            end else if (w_div_tick && !w_expired[i]) begin
                w_tmr_nxt[i] = r_timer[i] + TMR_W'(1);
            end else begin
                w_tmr_nxt[i] = r_timer[i];
            end
            if (w_rsp_hit && (r_slot == SLOT_W'(i))) begin
                w_hp_nxt[i] = (hp_base > DMG) ? (hp_base - DMG) : '0;
                if ((hp_base != '0) && (hp_base <= DMG)) begin
                    w_score_inc  = 1'b1;
                    w_tmr_nxt[i] = '0;
                end
            end
            w_alive_nxt[i] = (w_hp_nxt[i] != '0);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_frm_d1    <= 1'b0;
            r_frm_d2    <= 1'b0;
            r_div_cnt   <= '0;
            r_slot      <= '0;
            r_chk_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_score     <= '0;
            r_alive     <= ALIVE_ALL;
            for (int i = 0; i < int'(ENEMY_NUM); i++) begin
                r_hp[i]    <= HP_MAX;
                r_timer[i] <= '0;
            end
        end else begin
            r_frm_d1 <= frame_clk;
            r_frm_d2 <= r_frm_d1;
            if (w_tick) begin
                r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);
            end
            if (w_tick && Attack_On && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            for (int i = 0; i < int'(ENEMY_NUM); i++) begin
                r_hp[i]    <= w_hp_nxt[i];
                r_timer[i] <= w_tmr_nxt[i];
            end
            r_alive <= w_alive_nxt;
            if (w_score_inc && (r_score != 8'hFF)) begin
                r_score <= r_score + 8'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_tick && Attack_On) begin
                        r_state <= S_ISSUE;
                        r_slot  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (!r_alive[r_slot]) begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_slot <= r_slot + SLOT_W'(1);
                        end
                    end else if (!r_chk_valid) begin
                        r_chk_valid <= 1'b1;
                    end else if (Chk_Ready) begin
                        r_chk_valid <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (Rsp_Valid) begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_slot  <= r_slot + SLOT_W'(1);
                            r_state <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Chk_Valid    = r_chk_valid;
    assign Chk_Slot     = r_slot;
    assign Enemy_Alive  = r_alive;
    assign Score        = r_score;
    assign Scan_Busy    = r_busy;
    assign Scan_Overrun = r_overrun;

endmodule

// File: tb/tb_enemy_scan_ctrl.sv
// Bench for enemy_scan_ctrl: scan vector table plus directed respawn, backpressure, reset and damage sequences.
// Honours RESPAWN_STAGGER_EN when computing respawn expectations.
module tb_enemy_scan_ctrl;

    logic       clk = 1'b0;
    logic       Reset_n;
    logic       frame_clk, Attack_On, Chk_Ready;
    logic       Chk_Valid, Scan_Busy, Scan_Overrun;
    logic [2:0] Chk_Slot;
    logic [7:0] Enemy_Alive, Score;
    logic       auto_v = 1'b0, auto_h = 1'b0, man_v, man_h;
    logic       Rsp_Valid, Rsp_Hit;

    logic       frame_clk2, attack2;
    logic       Chk_Valid2, Scan_Busy2, Scan_Overrun2;
    logic [2:0] Chk_Slot2;
    logic [7:0] Enemy_Alive2, Score2;
    logic       Rsp_Valid2 = 1'b0, Rsp_Hit2 = 1'b0;

    always #5 clk = ~clk;

    assign Rsp_Valid = auto_v | man_v;
    assign Rsp_Hit   = auto_h | man_h;

    enemy_scan_ctrl u_dut (
        .Clk(clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .Attack_On(Attack_On),
        .Chk_Valid(Chk_Valid), .Chk_Slot(Chk_Slot), .Chk_Ready(Chk_Ready),
        .Rsp_Valid(Rsp_Valid), .Rsp_Hit(Rsp_Hit), .Enemy_Alive(Enemy_Alive),
        .Score(Score), .Scan_Busy(Scan_Busy), .Scan_Overrun(Scan_Overrun)
    );

    enemy_scan_ctrl #(.DAMAGE(40)) u_dut40 (
        .Clk(clk), .Reset_n(Reset_n), .frame_clk(frame_clk2), .Attack_On(attack2),
        .Chk_Valid(Chk_Valid2), .Chk_Slot(Chk_Slot2), .Chk_Ready(1'b1),
        .Rsp_Valid(Rsp_Valid2), .Rsp_Hit(Rsp_Hit2), .Enemy_Alive(Enemy_Alive2),
        .Score(Score2), .Scan_Busy(Scan_Busy2), .Scan_Overrun(Scan_Overrun2)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         tb_ticks = 0;
    logic [7:0] hit_mask = 8'h00;
    logic       resp_en = 1'b1;
    int         cnt0 = 0, cnt2 = 0;
    logic [2:0] slot0 = '0, slot2 = '0;
    int         log0[$];

    // Hit-test unit model: answers two cycles after each accepted request.
    always @(negedge clk) begin
        #1;
        auto_v = 1'b0;
        auto_h = 1'b0;
        if (!Reset_n) begin
            cnt0 = 0;
        end else begin
            if (cnt0 > 0) begin
                cnt0--;
                if (cnt0 == 0) begin
                    auto_v = 1'b1;
                    auto_h = hit_mask[slot0];
                end
            end
            if (Chk_Valid && Chk_Ready) begin
                log0.push_back(int'(Chk_Slot));
                if (resp_en) begin
                    cnt0  = 2;
                    slot0 = Chk_Slot;
                end
            end
        end
    end

    // Second unit model: only slot 3 ever reports a hit.
    always @(negedge clk) begin
        #1;
        Rsp_Valid2 = 1'b0;
        Rsp_Hit2   = 1'b0;
        if (!Reset_n) begin
            cnt2 = 0;
        end else begin
            if (cnt2 > 0) begin
                cnt2--;
                if (cnt2 == 0) begin
                    Rsp_Valid2 = 1'b1;
                    Rsp_Hit2   = (slot2 == 3'd3);
                end
            end
            if (Chk_Valid2) begin
                cnt2  = 2;
                slot2 = Chk_Slot2;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset_n = 1'b0;
        repeat (3) @(negedge clk);
        Reset_n = 1'b1;
        @(negedge clk);
        tb_ticks = 0;
    endtask

    task automatic tick_frame(input int which, input logic atk);
        @(negedge clk);
        if (which == 0) begin Attack_On = atk; frame_clk = 1'b1; end
        else begin attack2 = atk; frame_clk2 = 1'b1; end
        repeat (2) @(negedge clk);
        frame_clk = 1'b0; frame_clk2 = 1'b0; Attack_On = 1'b0; attack2 = 1'b0;
        repeat (2) @(negedge clk);
        if (which == 0) tb_ticks++;
    endtask

    task automatic wait_idle(input int which, input string name);
        int n = 0;
        while (((which == 0) ? Scan_Busy : Scan_Busy2) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check(name, 32'(n), 32'(0));
    endtask

    function automatic logic [7:0] exp_respawn(input int d);
        int k;
        if (d < 201) return 8'h00;
        k = d - 200;
`ifdef RESPAWN_STAGGER_EN
        if (k >= 8) return 8'hFF;
        return 8'((1 << k) - 1);
`else
        return 8'hFF;
`endif
    endfunction

    typedef struct {
        logic       atk;
        logic [7:0] mask;
        int         checks;
        logic [7:0] alive;
        logic [7:0] score;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic stable;
        int   n;
        vecs[0] = '{1'b0, 8'hFF, 0, 8'hFF, 8'd0};
        vecs[1] = '{1'b1, 8'h01, 8, 8'hFE, 8'd1};
        vecs[2] = '{1'b1, 8'h24, 7, 8'hDA, 8'd3};
        vecs[3] = '{1'b1, 8'h00, 5, 8'hDA, 8'd3};
        vecs[4] = '{1'b1, 8'hFF, 5, 8'h00, 8'd8};
        vecs[5] = '{1'b1, 8'hFF, 0, 8'h00, 8'd8};

        Reset_n = 1'b0; frame_clk = 1'b0; Attack_On = 1'b0; Chk_Ready = 1'b1;
        frame_clk2 = 1'b0; attack2 = 1'b0; man_v = 1'b0; man_h = 1'b0;
        do_reset();
        check("rst_alive", 32'(Enemy_Alive), 32'hFF);
        check("rst_score", 32'(Score), 32'h0);
        check("rst_valid", 32'(Chk_Valid), 32'h0);
        check("rst_slot", 32'(Chk_Slot), 32'h0);
        check("rst_busy", 32'(Scan_Busy), 32'h0);
        check("rst_overrun", 32'(Scan_Overrun), 32'h0);

        for (int v = 0; v < 6; v++) begin
            log0.delete();
            hit_mask = vecs[v].mask;
            tick_frame(0, vecs[v].atk);
            wait_idle(0, $sformatf("vec%0d_timeout", v));
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_alive", v), 32'(Enemy_Alive), 32'(vecs[v].alive));
            check($sformatf("vec%0d_score", v), 32'(Score), 32'(vecs[v].score));
            check($sformatf("vec%0d_checks", v), 32'(log0.size()), 32'(vecs[v].checks));
        end

        // Full kill scan, then respawn timing of all eight slots.
        do_reset();
        log0.delete();
        hit_mask = 8'hFF;
        tick_frame(0, 1'b1);
        wait_idle(0, "kill_all_timeout");
        repeat (2) @(negedge clk);
        check("kill_all_checks", 32'(log0.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < log0.size()) check($sformatf("kill_all_order%0d", i), 32'(log0[i]), 32'(i));
        end
        check("kill_all_alive", 32'(Enemy_Alive), 32'h00);
        check("kill_all_score", 32'(Score), 32'd8);
        check("kill_all_busy", 32'(Scan_Busy), 32'd0);
        while (tb_ticks < 4 * 209) begin
            tick_frame(0, 1'b0);
            if ((tb_ticks % 4) == 0 && (tb_ticks / 4) >= 199)
                check($sformatf("respawn_all_d%0d", tb_ticks / 4), 32'(Enemy_Alive), 32'(exp_respawn(tb_ticks / 4)));
        end

        // Single slot kill and its respawn on divided tick 201.
        do_reset();
        hit_mask = 8'h20;
        tick_frame(0, 1'b1);
        wait_idle(0, "kill5_timeout");
        repeat (2) @(negedge clk);
        check("kill5_alive", 32'(Enemy_Alive), 32'hDF);
        check("kill5_score", 32'(Score), 32'd1);
        while (tb_ticks < 4 * 201) begin
            tick_frame(0, 1'b0);
            if ((tb_ticks % 4) == 0 && (tb_ticks / 4) >= 200)
                check($sformatf("respawn5_d%0d", tb_ticks / 4), 32'(Enemy_Alive),
                      ((tb_ticks / 4) >= 201) ? 32'hFF : 32'hDF);
        end

        // Backpressure hold and overrun on a mid-scan attack tick.
        do_reset();
        log0.delete();
        hit_mask = 8'h00;
        Chk_Ready = 1'b0;
        tick_frame(0, 1'b1);
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!(Chk_Valid === 1'b1 && Chk_Slot === 3'd0)) stable = 1'b0;
        end
        tick_frame(0, 1'b1);
        if (!(Chk_Valid === 1'b1 && Chk_Slot === 3'd0)) stable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (!(Chk_Valid === 1'b1 && Chk_Slot === 3'd0)) stable = 1'b0;
        end
        check("ready_low_hold", 32'(stable), 32'd1);
        check("overrun_set", 32'(Scan_Overrun), 32'd1);
        Chk_Ready = 1'b1;
        wait_idle(0, "overrun_timeout");
        repeat (20) @(negedge clk);
        check("overrun_one_scan", 32'(log0.size()), 32'd8);
        check("overrun_busy", 32'(Scan_Busy), 32'd0);
        check("overrun_sticky", 32'(Scan_Overrun), 32'd1);

        // Reset while waiting for a response; late response must be ignored.
        do_reset();
        hit_mask = 8'h01;
        tick_frame(0, 1'b1);
        wait_idle(0, "prekill_timeout");
        check("prekill_score", 32'(Score), 32'd1);
        resp_en = 1'b0;
        hit_mask = 8'hFF;
        log0.delete();
        tick_frame(0, 1'b1);
        n = 0;
        while (log0.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_reached", 32'(log0.size() > 0), 32'd1);
        Reset_n = 1'b0;
        repeat (2) @(negedge clk);
        Reset_n = 1'b1;
        @(negedge clk);
        man_v = 1'b1; man_h = 1'b1;
        @(negedge clk);
        man_v = 1'b0; man_h = 1'b0;
        repeat (3) @(negedge clk);
        check("late_rsp_alive", 32'(Enemy_Alive), 32'hFF);
        check("late_rsp_score", 32'(Score), 32'd0);
        check("late_rsp_busy", 32'(Scan_Busy), 32'd0);
        check("late_rsp_valid", 32'(Chk_Valid), 32'd0);
        check("late_rsp_overrun", 32'(Scan_Overrun), 32'd0);
        resp_en = 1'b1;

        // DAMAGE=40 instance: slot 3 goes 100 -> 60 -> 20 -> 0 without wrapping.
        for (int s = 1; s <= 4; s++) begin
            tick_frame(1, 1'b1);
            wait_idle(1, $sformatf("dmg_scan%0d_timeout", s));
            repeat (2) @(negedge clk);
            check($sformatf("dmg_scan%0d_alive", s), 32'(Enemy_Alive2), (s >= 3) ? 32'hF7 : 32'hFF);
            check($sformatf("dmg_scan%0d_score", s), 32'(Score2), (s >= 3) ? 32'd1 : 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
